// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use stall, redirect flushes, EX forwarding selects and ID write-back bypass for a 5-stage MIPS pipe.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ENABLE_FORWARDING = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  wb_bypass_a,
  output logic                  wb_bypass_b,
  output logic [CNT_W-1:0]      stall_count
);
  localparam bit FWD = ENABLE_FORWARDING != 0;
  logic                  ex_v_q, ex_urs_q, ex_urt_q, ex_rw_q, ex_mr_q;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q, ex_dest_q;
  logic                  mem_v_q, mem_rw_q, mem_mr_q;
  logic [REG_ADDR_W-1:0] mem_dest_q;
  logic                  wb_v_q, wb_rw_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  need_ex, need_mem, need_wb, stall_d;
  // a slot writing $0 or not writing at all never matches
  function automatic logic hit(input logic v, input logic rw, input logic [REG_ADDR_W-1:0] dest,
                               input logic [REG_ADDR_W-1:0] r);
    return v & rw & (dest != '0) & (dest == r);
  endfunction
  always_comb begin
    need_ex  = id_valid & ((id_uses_rs & hit(ex_v_q, ex_rw_q, ex_dest_q, id_rs)) |
                           (id_uses_rt & hit(ex_v_q, ex_rw_q, ex_dest_q, id_rt)));
    need_mem = id_valid & ((id_uses_rs & hit(mem_v_q, mem_rw_q, mem_dest_q, id_rs)) |
                           (id_uses_rt & hit(mem_v_q, mem_rw_q, mem_dest_q, id_rt)));
    need_wb  = id_valid & ((id_uses_rs & hit(wb_v_q, wb_rw_q, wb_dest_q, id_rs)) |
                           (id_uses_rt & hit(wb_v_q, wb_rw_q, wb_dest_q, id_rt)));
    stall_d  = (FWD ? (ex_mr_q & need_ex) : (need_ex | need_mem | need_wb)) & !redirect;
    stall       = stall_d & !reset;
    if_id_flush = redirect & !reset;
    id_ex_flush = redirect & !reset;
    fwd_a_sel   = (!FWD || reset) ? 2'b00 :
                  (ex_urs_q & !mem_mr_q & hit(mem_v_q, mem_rw_q, mem_dest_q, ex_rs_q)) ? 2'b10 :
                  (ex_urs_q & hit(wb_v_q, wb_rw_q, wb_dest_q, ex_rs_q)) ? 2'b01 : 2'b00;
    fwd_b_sel   = (!FWD || reset) ? 2'b00 :
                  (ex_urt_q & !mem_mr_q & hit(mem_v_q, mem_rw_q, mem_dest_q, ex_rt_q)) ? 2'b10 :
                  (ex_urt_q & hit(wb_v_q, wb_rw_q, wb_dest_q, ex_rt_q)) ? 2'b01 : 2'b00;
    wb_bypass_a = FWD & !reset & id_valid & id_uses_rs & hit(wb_v_q, wb_rw_q, wb_dest_q, id_rs);
    wb_bypass_b = FWD & !reset & id_valid & id_uses_rt & hit(wb_v_q, wb_rw_q, wb_dest_q, id_rt);
    stall_count = reset ? '0 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wb_v_q     <= mem_v_q;
      wb_rw_q    <= mem_rw_q;
      wb_dest_q  <= mem_dest_q;
      mem_v_q    <= ex_v_q;
      mem_rw_q   <= ex_rw_q;
      mem_mr_q   <= ex_mr_q;
      mem_dest_q <= ex_dest_q;
      ex_v_q     <= id_valid & !stall_d & !redirect;
      if (stall_d && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    ex_rs_q   <= id_rs;
    ex_rt_q   <= id_rt;
    ex_urs_q  <= id_uses_rs;
    ex_urt_q  <= id_uses_rt;
    ex_rw_q   <= id_reg_write;
    ex_mr_q   <= id_mem_read;
    ex_dest_q <= id_dest;
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed scenarios on a forwarding instance and a stall-only, 2-bit-counter instance.
module tb_pipeline_hazard_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, redirect = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic s0_stall, s0_iff, s0_ief, s0_ba, s0_bb;
  logic [1:0] s0_fa, s0_fb;
  logic [15:0] s0_cnt;
  logic s1_stall, s1_iff, s1_ief, s1_ba, s1_bb;
  logic [1:0] s1_fa, s1_fb;
  logic [1:0] s1_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit d0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .redirect(redirect),
    .stall(s0_stall), .if_id_flush(s0_iff), .id_ex_flush(s0_ief), .fwd_a_sel(s0_fa),
    .fwd_b_sel(s0_fb), .wb_bypass_a(s0_ba), .wb_bypass_b(s0_bb), .stall_count(s0_cnt));

  pipeline_hazard_unit #(.ENABLE_FORWARDING(0), .CNT_W(2)) d1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .redirect(redirect),
    .stall(s1_stall), .if_id_flush(s1_iff), .id_ex_flush(s1_ief), .fwd_a_sel(s1_fa),
    .fwd_b_sel(s1_fb), .wb_bypass_a(s1_ba), .wb_bypass_b(s1_bb), .stall_count(s1_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                    input logic rw, input logic mr, input int dest);
    id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_dest = dest[4:0];
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b1; id(1, 8, 8, 1, 1, 1, 1, 8);
    #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", s0_stall); end
    n_tests++; if ({s0_iff, s0_ief} !== 2'b00) begin n_fail++; $display("FAIL rst_flush got %b exp 00", {s0_iff, s0_ief}); end
    n_tests++; if (s1_iff !== 1'b0) begin n_fail++; $display("FAIL rst_flush_nf got %b exp 0", s1_iff); end
    tick();
    reset = 1'b0; redirect = 1'b0; id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall got %b exp 0", s0_stall); end
    n_tests++; if ({s0_fa, s0_fb} !== 4'b0000) begin n_fail++; $display("FAIL post_rst_fwd got %b exp 0000", {s0_fa, s0_fb}); end
    n_tests++; if (s0_cnt !== 16'd0) begin n_fail++; $display("FAIL post_rst_cnt got %0d exp 0", s0_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    id(1, 29, 0, 1, 0, 1, 1, 8); #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall got %b exp 0", s0_stall); end
    tick();
    id(1, 8, 10, 1, 1, 1, 0, 9); #1;
    n_tests++; if (s0_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", s0_stall); end
    tick(); #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", s0_stall); end
    n_tests++; if (s0_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got %0d exp 1", s0_cnt); end
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_tests++; if (s0_fa !== 2'b01) begin n_fail++; $display("FAIL lu_fwd_a got %b exp 01", s0_fa); end
    n_tests++; if (s0_fb !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b got %b exp 00", s0_fb); end
    n_tests++; if (s0_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold got %0d exp 1", s0_cnt); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    id(1, 1, 2, 1, 1, 1, 0, 9);
    tick();
    id(1, 12, 9, 1, 1, 1, 0, 11); #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", s0_stall); end
    n_tests++; if (s1_stall !== 1'b1) begin n_fail++; $display("FAIL alu_nf_stall got %b exp 1", s1_stall); end
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_tests++; if (s0_fb !== 2'b10) begin n_fail++; $display("FAIL alu_fwd_b got %b exp 10", s0_fb); end
    n_tests++; if (s0_fa !== 2'b00) begin n_fail++; $display("FAIL alu_fwd_a got %b exp 00", s0_fa); end
    n_tests++; if (s1_fb !== 2'b00) begin n_fail++; $display("FAIL alu_nf_fwd_b got %b exp 00", s1_fb); end
  endtask

  task automatic test_priority_bypass();
    do_reset();
    id(1, 1, 0, 1, 0, 1, 0, 10); tick();
    id(1, 2, 0, 1, 0, 1, 0, 10); tick();
    id(1, 10, 4, 1, 1, 1, 0, 3); tick();
    id(1, 0, 0, 1, 0, 1, 0, 5); #1;
    n_tests++; if (s0_fa !== 2'b10) begin n_fail++; $display("FAIL prio_fwd_a got %b exp 10", s0_fa); end
    n_tests++; if (s0_fb !== 2'b00) begin n_fail++; $display("FAIL prio_fwd_b got %b exp 00", s0_fb); end
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    id(1, 5, 6, 1, 1, 1, 0, 7); #1;
    n_tests++; if (s0_ba !== 1'b1) begin n_fail++; $display("FAIL byp_a got %b exp 1", s0_ba); end
    n_tests++; if (s0_bb !== 1'b0) begin n_fail++; $display("FAIL byp_b got %b exp 0", s0_bb); end
    n_tests++; if (s1_ba !== 1'b0) begin n_fail++; $display("FAIL byp_a_nf got %b exp 0", s1_ba); end
    id(0, 5, 6, 1, 1, 1, 0, 7); #1;
    n_tests++; if (s0_ba !== 1'b0) begin n_fail++; $display("FAIL byp_invalid got %b exp 0", s0_ba); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    id(1, 1, 0, 1, 0, 1, 1, 0); tick();
    id(1, 0, 0, 1, 1, 1, 0, 0); #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %b exp 0", s0_stall); end
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL r0_nf_stall got %b exp 0", s1_stall); end
    tick(); tick(); #1;
    n_tests++; if ({s0_fa, s0_fb} !== 4'b0000) begin n_fail++; $display("FAIL r0_fwd got %b exp 0000", {s0_fa, s0_fb}); end
    n_tests++; if ({s0_ba, s0_bb} !== 2'b00) begin n_fail++; $display("FAIL r0_byp got %b exp 00", {s0_ba, s0_bb}); end
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL r0_nf_stall2 got %b exp 0", s1_stall); end
  endtask

  task automatic test_redirect();
    do_reset();
    id(1, 29, 0, 1, 0, 1, 1, 8); tick();
    id(1, 8, 10, 1, 1, 1, 0, 9); redirect = 1'b1; #1;
    n_tests++; if (s0_stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall got %b exp 0", s0_stall); end
    n_tests++; if ({s0_iff, s0_ief} !== 2'b11) begin n_fail++; $display("FAIL rd_flush got %b exp 11", {s0_iff, s0_ief}); end
    tick();
    redirect = 1'b0; id(1, 9, 0, 1, 0, 1, 0, 11); #1;
    n_tests++; if (s0_cnt !== 16'd0) begin n_fail++; $display("FAIL rd_cnt got %0d exp 0", s0_cnt); end
    n_tests++; if ({s0_iff, s0_ief} !== 2'b00) begin n_fail++; $display("FAIL rd_flush_off got %b exp 00", {s0_iff, s0_ief}); end
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_tests++; if (s0_fa !== 2'b00) begin n_fail++; $display("FAIL rd_killed_fwd got %b exp 00", s0_fa); end
  endtask

  task automatic test_no_fwd_saturate();
    do_reset();
    id(1, 1, 2, 1, 1, 1, 0, 9); #1;
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL nf_first got %b exp 0", s1_stall); end
    tick();
    id(1, 9, 2, 1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (s1_stall !== 1'b1) begin n_fail++; $display("FAIL nf_stall%0d got %b exp 1", i, s1_stall); end
      n_tests++; if (s1_cnt !== 2'(i)) begin n_fail++; $display("FAIL nf_cnt%0d got %0d exp %0d", i, s1_cnt, i); end
      tick();
    end
    #1;
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL nf_release got %b exp 0", s1_stall); end
    n_tests++; if (s1_cnt !== 2'd3) begin n_fail++; $display("FAIL nf_cnt_max got %0d exp 3", s1_cnt); end
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); tick();
    id(1, 1, 2, 1, 1, 1, 0, 3);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (s1_stall !== 1'b1) begin n_fail++; $display("FAIL nf_sat_stall%0d got %b exp 1", i, s1_stall); end
      tick();
    end
    #1;
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL nf_sat_release got %b exp 0", s1_stall); end
    n_tests++; if (s1_cnt !== 2'd3) begin n_fail++; $display("FAIL nf_sat_cnt got %0d exp 3", s1_cnt); end
    tick();
    id(1, 3, 0, 1, 0, 1, 0, 4); #1;
    n_tests++; if (s1_stall !== 1'b1) begin n_fail++; $display("FAIL nf_pre_rst got %b exp 1", s1_stall); end
    reset = 1'b1; #1;
    n_tests++; if ({s1_stall, s1_cnt} !== 3'b000) begin n_fail++; $display("FAIL nf_in_rst got %b exp 000", {s1_stall, s1_cnt}); end
    tick();
    reset = 1'b0; #1;
    n_tests++; if (s1_stall !== 1'b0) begin n_fail++; $display("FAIL nf_post_rst_stall got %b exp 0", s1_stall); end
    n_tests++; if (s1_cnt !== 2'd0) begin n_fail++; $display("FAIL nf_post_rst_cnt got %0d exp 0", s1_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_priority_bypass();
    test_reg_zero();
    test_redirect();
    test_no_fwd_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
